// File: rtl/sv_timer_pkg.sv
// Shared register offsets, CTRL layout and prescale selection for the
// Supervision multi-channel timer.
package sv_timer_pkg;

  localparam logic [1:0] REG_CNT_LO = 2'd0;
  localparam logic [1:0] REG_CNT_HI = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_AUTO    = 2;
  localparam int CTRL_PSEL_LO = 3;
  localparam int CTRL_W       = 5;

  typedef enum logic [1:0] {
    PS_CE  = 2'd0,
    PS_A   = 2'd1,
    PS_B   = 2'd2,
    PS_EXT = 2'd3
  } psel_t;

  // STATUS sits directly after the last channel's register window.
  function automatic int status_addr(input int n_ch);
    return 4 * n_ch;
  endfunction

endpackage

// File: rtl/sv_timer_channel.sv
// One timer channel: staged load, reload value, CTRL and the down-counter.
// set_pend_o pulses on expiry or on committing a zero count.
module sv_timer_channel
  import sv_timer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              tick_ce_i,
  input  logic              tick_a_i,
  input  logic              tick_b_i,
  input  logic              tick_ext_i,
  input  logic              wr_lo_i,
  input  logic              wr_hi_i,
  input  logic              wr_ctrl_i,
  input  logic [7:0]        din_i,
  output logic [CNT_W-1:0]  count_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              set_pend_o
);

  logic [CNT_W-1:0]  count_q, count_d, reload_q, commit_val;
  logic [7:0]        staging_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [15:0]       full_val;
  logic              commit, tick_src, tick, expire;
  psel_t             psel;

  generate
    if (CNT_W > 8) begin : g_wide
      assign commit   = wr_hi_i;
      assign full_val = {din_i, staging_q};
    end else begin : g_narrow
      assign commit   = wr_lo_i;
      assign full_val = {8'h00, din_i};
    end
  endgenerate

  assign commit_val = full_val[CNT_W-1:0];
  assign psel       = psel_t'(ctrl_q[CTRL_PSEL_LO +: 2]);

  always_comb begin
    tick_src = 1'b0;
    case (psel)
      PS_CE:   tick_src = tick_ce_i;
      PS_A:    tick_src = tick_a_i;
      PS_B:    tick_src = tick_b_i;
      PS_EXT:  tick_src = tick_ext_i;
      default: tick_src = 1'b0;
    endcase
  end

  // ctrl_q is the pre-write value, so a tick coinciding with a CTRL write uses the old settings.
  assign tick = tick_src & ctrl_q[CTRL_EN];

  always_comb begin
    count_d = count_q;
    expire  = 1'b0;
    if (commit) begin
      count_d = commit_val;
    end else if (tick && count_q != '0) begin
      if (count_q == CNT_W'(1)) begin
        expire  = 1'b1;
        count_d = ctrl_q[CTRL_AUTO] ? reload_q : '0;
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      count_q   <= '0;
      reload_q  <= '0;
      staging_q <= '0;
      ctrl_q    <= '0;
    end else begin
      count_q <= count_d;
      if (commit)    reload_q  <= commit_val;
      if (wr_lo_i)   staging_q <= din_i;
      if (wr_ctrl_i) ctrl_q    <= din_i[CTRL_W-1:0];
    end
  end

  assign count_o    = count_q;
  assign ctrl_o     = ctrl_q;
  assign set_pend_o = expire | (commit && commit_val == '0);

endmodule

// File: rtl/sv_timer_unit.sv
// Multi-channel interval timer with W1C pending register and combined IRQ;
// holds the shared prescaler, register decode and read mux.
module sv_timer_unit
  import sv_timer_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int CNT_W  = 16,
  parameter int PRE_A  = 8,
  parameter int PRE_B  = 14,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              ext_tick,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              irq
);

  localparam int STATUS_ADDR = status_addr(N_CH);

  logic [PRE_B-1:0]  pre_q;
  logic              tick_a, tick_b, tick_ext, wr_stat;
  logic [N_CH-1:0]   pend_q, pend_d, set_pend, irq_en;
  logic [ADDR_W-3:0] ch_sel;
  logic [1:0]        reg_off;
  logic [7:0]        lo_rd   [N_CH];
  logic [7:0]        hi_rd   [N_CH];
  logic [7:0]        ctrl_rd [N_CH];

  assign ch_sel   = addr[ADDR_W-1:2];
  assign reg_off  = addr[1:0];
  assign tick_a   = ce & (&pre_q[PRE_A-1:0]);
  assign tick_b   = ce & (&pre_q);
  assign tick_ext = ce & ext_tick;
  assign wr_stat  = cs && we && (addr == ADDR_W'(STATUS_ADDR));

  always_ff @(posedge clk) begin
    if (reset) pre_q <= '0;
    else if (ce) pre_q <= pre_q + PRE_B'(1);
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic              sel;
      logic [CNT_W-1:0]  count;
      logic [CTRL_W-1:0] ctrl;
      logic [15:0]       count_ext;

      assign sel       = cs && (ch_sel == (ADDR_W-2)'(gi));
      assign count_ext = 16'(count);

      sv_timer_channel #(.CNT_W(CNT_W)) u_ch (
        .clk       (clk),
        .reset_i   (reset),
        .tick_ce_i (ce),
        .tick_a_i  (tick_a),
        .tick_b_i  (tick_b),
        .tick_ext_i(tick_ext),
        .wr_lo_i   (sel && we && reg_off == REG_CNT_LO),
        .wr_hi_i   (sel && we && reg_off == REG_CNT_HI),
        .wr_ctrl_i (sel && we && reg_off == REG_CTRL),
        .din_i     (din),
        .count_o   (count),
        .ctrl_o    (ctrl),
        .set_pend_o(set_pend[gi])
      );

      assign lo_rd[gi]   = count_ext[7:0];
      assign ctrl_rd[gi] = {3'b000, ctrl};
      assign irq_en[gi]  = ctrl[CTRL_IRQ_EN];

      if (CNT_W > 8) begin : g_latch
        // Reading LO snapshots the upper byte so a following HI read is coherent.
        logic [7:0] latch_q;
        always_ff @(posedge clk) begin
          if (reset) latch_q <= '0;
          else if (sel && !we && reg_off == REG_CNT_LO) latch_q <= count_ext[15:8];
        end
        assign hi_rd[gi] = latch_q;
      end else begin : g_no_latch
        assign hi_rd[gi] = 8'h00;
      end
    end
  endgenerate

  always_comb begin
    dout = 8'hFF;
    if (addr == ADDR_W'(STATUS_ADDR)) dout = 8'(pend_q);
    for (int i = 0; i < N_CH; i++) begin
      if (ch_sel == (ADDR_W-2)'(i)) begin
        case (reg_off)
          REG_CNT_LO: dout = lo_rd[i];
          REG_CNT_HI: dout = hi_rd[i];
          REG_CTRL:   dout = ctrl_rd[i];
          default:    dout = 8'h00;
        endcase
      end
    end
  end

  // Set wins over a same-edge W1C of the same bit.
  always_comb begin
    pend_d = pend_q;
    if (wr_stat) pend_d = pend_d & ~din[N_CH-1:0];
    pend_d = pend_d | set_pend;
  end

  always_ff @(posedge clk) begin
    if (reset) pend_q <= '0;
    else pend_q <= pend_d;
  end

  assign irq = |(pend_q & irq_en);

endmodule

// File: tb/tb_sv_timer_unit.sv
// Self-checking bench for sv_timer_unit: directed scenarios plus a randomized
// run scored against a cycle-level behavioural model of the register map.
module tb_sv_timer_unit;
  localparam int N_CH = 2, CNT_W = 16, PRE_A = 4, PRE_B = 8, ADDR_W = 4;
  localparam int TA = 1 << PRE_A, TB = 1 << PRE_B, STAT = 4 * N_CH;

  logic clk = 1'b0;
  logic reset, ce, ext_tick, cs, we, irq;
  logic [ADDR_W-1:0] addr;
  logic [7:0] din, dout;

  int n_checks = 0, n_pass = 0;

  int m_cnt[N_CH], m_rel[N_CH], m_stg[N_CH], m_ctrl[N_CH], m_latch[N_CH];
  int m_pend, m_pre;

  always #5 clk = ~clk;

  sv_timer_unit #(.N_CH(N_CH), .CNT_W(CNT_W), .PRE_A(PRE_A), .PRE_B(PRE_B), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .ce(ce), .ext_tick(ext_tick), .cs(cs), .we(we),
    .addr(addr), .din(din), .dout(dout), .irq(irq)
  );

  // Reference: what one clock edge does to the register-level state.
  task automatic model_update();
    int set_m, clr_m, v, ps;
    bit tk;
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        m_cnt[i] = 0; m_rel[i] = 0; m_stg[i] = 0; m_ctrl[i] = 0; m_latch[i] = 0;
      end
      m_pend = 0; m_pre = 0;
      return;
    end
    set_m = 0;
    clr_m = (cs && we && int'(addr) == STAT) ? int'(din) : 0;
    for (int i = 0; i < N_CH; i++) begin
      ps = (m_ctrl[i] >> 3) & 3;
      if (ps == 0) tk = 1'b1;
      else if (ps == 1) tk = (m_pre % TA) == TA - 1;
      else if (ps == 2) tk = (m_pre == TB - 1);
      else tk = ext_tick;
      tk = tk && ce && (m_ctrl[i] & 1) != 0;
      if (cs && !we && int'(addr) == 4 * i) m_latch[i] = (m_cnt[i] >> 8) & 255;
      if (cs && we && int'(addr) == 4 * i + 1) begin
        v = ((int'(din) << 8) | m_stg[i]) & 16'hFFFF;
        m_cnt[i] = v; m_rel[i] = v;
        if (v == 0) set_m |= (1 << i);
      end else if (tk && m_cnt[i] > 0) begin
        if (m_cnt[i] == 1) begin
          set_m |= (1 << i);
          m_cnt[i] = ((m_ctrl[i] & 4) != 0) ? m_rel[i] : 0;
        end else begin
          m_cnt[i] = m_cnt[i] - 1;
        end
      end
      if (cs && we && int'(addr) == 4 * i) m_stg[i] = int'(din);
      if (cs && we && int'(addr) == 4 * i + 2) m_ctrl[i] = int'(din) & 31;
    end
    m_pend = ((m_pend & ~clr_m) | set_m) & ((1 << N_CH) - 1);
    if (ce) m_pre = (m_pre + 1) % TB;
  endtask

  function automatic int model_read(input int a);
    if (a < 4 * N_CH) begin
      case (a % 4)
        0: return m_cnt[a / 4] & 255;
        1: return m_latch[a / 4];
        2: return m_ctrl[a / 4];
        default: return 0;
      endcase
    end
    if (a == STAT) return m_pend;
    return 255;
  endfunction

  function automatic bit model_irq();
    for (int i = 0; i < N_CH; i++)
      if (((m_pend >> i) & 1) != 0 && ((m_ctrl[i] >> 1) & 1) != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    cs = 1'b1; we = 1'b1; addr = ADDR_W'(a); din = 8'(d);
    step();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input int a, output logic [7:0] v);
    cs = 1'b1; we = 1'b0; addr = ADDR_W'(a);
    #1;
    v = dout;
    step();
    cs = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset = 1'b1; ce = 1'b0; ext_tick = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; din = '0;
    step(); step();
    reset = 1'b0;
    n_checks++;
    if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
    for (int a = 0; a < 16; a++) begin
      rd(a, v);
      n_checks++;
      if (v !== ((a <= STAT) ? 8'h00 : 8'hFF))
        $display("FAIL reset_read a=%0d: got %02h want %02h", a, v, (a <= STAT) ? 8'h00 : 8'hFF);
      else n_pass++;
    end
  endtask

  task automatic test_oneshot();
    logic [7:0] v;
    ce = 1'b0;
    wr(2, 8'h03); wr(0, 8'h03); wr(1, 8'h00);
    rd(0, v);
    n_checks++; if (v !== 8'h03) $display("FAIL oneshot_load: got %02h want 03", v); else n_pass++;
    ce = 1'b1; step(); step();
    n_checks++; if (irq !== 1'b0) $display("FAIL oneshot_early: got %b want 0", irq); else n_pass++;
    step();
    n_checks++; if (irq !== 1'b1) $display("FAIL oneshot_irq: got %b want 1", irq); else n_pass++;
    repeat (5) step();
    ce = 1'b0;
    rd(0, v);
    n_checks++; if (v !== 8'h00) $display("FAIL oneshot_idle: got %02h want 00", v); else n_pass++;
    rd(STAT, v);
    n_checks++; if (v !== 8'h01) $display("FAIL oneshot_status: got %02h want 01", v); else n_pass++;
    wr(STAT, 8'h01);
    n_checks++; if (irq !== 1'b0) $display("FAIL oneshot_w1c: got %b want 0", irq); else n_pass++;
  endtask

  task automatic test_autoreload();
    logic [7:0] v;
    int cycles, want;
    ce = 1'b0;
    wr(6, 8'h0F); wr(4, 8'h02); wr(5, 8'h01);
    want = ((TA - 1) - (m_pre % TA) + TA) % TA + 257 * TA + 1;
    ce = 1'b1; cycles = 0;
    while (irq !== 1'b1 && cycles < 20000) begin step(); cycles++; end
    ce = 1'b0;
    n_checks++; if (cycles != want) $display("FAIL auto_first: got %0d cycles want %0d", cycles, want); else n_pass++;
    rd(4, v);
    n_checks++; if (v !== 8'h02) $display("FAIL auto_reload_lo: got %02h want 02", v); else n_pass++;
    rd(5, v);
    n_checks++; if (v !== 8'h01) $display("FAIL auto_reload_hi: got %02h want 01", v); else n_pass++;
    rd(STAT, v);
    n_checks++; if (v !== 8'h02) $display("FAIL auto_status: got %02h want 02", v); else n_pass++;
    wr(STAT, 8'h02);
    ce = 1'b1; cycles = 0;
    while (irq !== 1'b1 && cycles < 20000) begin step(); cycles++; end
    ce = 1'b0;
    n_checks++; if (cycles != 258 * TA) $display("FAIL auto_second: got %0d cycles want %0d", cycles, 258 * TA); else n_pass++;
    wr(6, 8'h00); wr(STAT, 8'h02);
  endtask

  task automatic test_commit_zero();
    logic [7:0] v;
    ce = 1'b0;
    wr(2, 8'h02); wr(0, 8'h00);
    n_checks++; if (irq !== 1'b0) $display("FAIL zero_before: got %b want 0", irq); else n_pass++;
    wr(1, 8'h00);
    n_checks++; if (irq !== 1'b1) $display("FAIL zero_irq: got %b want 1", irq); else n_pass++;
    rd(STAT, v);
    n_checks++; if (v !== 8'h01) $display("FAIL zero_status: got %02h want 01", v); else n_pass++;
    wr(STAT, 8'h01);
  endtask

  task automatic test_collisions();
    logic [7:0] v;
    ce = 1'b0;
    wr(2, 8'h03); wr(0, 8'h00); wr(1, 8'h00);
    wr(0, 8'h02); wr(1, 8'h00);
    ce = 1'b1; step();
    wr(STAT, 8'h01);
    ce = 1'b0;
    n_checks++; if (irq !== 1'b1) $display("FAIL expire_w1c_irq: got %b want 1", irq); else n_pass++;
    rd(STAT, v);
    n_checks++; if (v !== 8'h01) $display("FAIL expire_w1c_status: got %02h want 01", v); else n_pass++;
    wr(STAT, 8'h01);
    n_checks++; if (irq !== 1'b0) $display("FAIL plain_w1c: got %b want 0", irq); else n_pass++;
    wr(0, 8'h50); wr(1, 8'h00);
    ce = 1'b1; repeat (3) step();
    wr(0, 8'h34); wr(1, 8'h12);
    ce = 1'b0;
    rd(0, v);
    n_checks++; if (v !== 8'h34) $display("FAIL commit_tick_lo: got %02h want 34", v); else n_pass++;
    rd(1, v);
    n_checks++; if (v !== 8'h12) $display("FAIL commit_tick_hi: got %02h want 12", v); else n_pass++;
    ce = 1'b1;
    wr(2, 8'h02);
    ce = 1'b0;
    rd(0, v);
    n_checks++; if (v !== 8'h33) $display("FAIL ctrl_old_tick: got %02h want 33", v); else n_pass++;
  endtask

  task automatic test_read_latch();
    logic [7:0] v;
    ce = 1'b0;
    wr(2, 8'h01); wr(0, 8'hFF); wr(1, 8'h12);
    rd(0, v);
    n_checks++; if (v !== 8'hFF) $display("FAIL latch_lo: got %02h want FF", v); else n_pass++;
    ce = 1'b1; step(); ce = 1'b0;
    rd(1, v);
    n_checks++; if (v !== 8'h12) $display("FAIL latch_hi: got %02h want 12", v); else n_pass++;
    rd(0, v);
    n_checks++; if (v !== 8'hFE) $display("FAIL latch_lo2: got %02h want FE", v); else n_pass++;
    wr(0, 8'h00); wr(1, 8'h13);
    rd(0, v);
    n_checks++; if (v !== 8'h00) $display("FAIL wrap_lo: got %02h want 00", v); else n_pass++;
    ce = 1'b1; step(); ce = 1'b0;
    rd(1, v);
    n_checks++; if (v !== 8'h13) $display("FAIL wrap_hi_coherent: got %02h want 13", v); else n_pass++;
    rd(0, v);
    n_checks++; if (v !== 8'hFF) $display("FAIL wrap_lo_live: got %02h want FF", v); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    ce = 1'b0;
    wr(2, 8'h03); wr(0, 8'h00); wr(1, 8'h00); wr(0, 8'h40); wr(1, 8'h00);
    ce = 1'b1; step();
    n_checks++; if (irq !== 1'b1) $display("FAIL mid_pre_irq: got %b want 1", irq); else n_pass++;
    reset = 1'b1; step(); reset = 1'b0; ce = 1'b0;
    n_checks++; if (irq !== 1'b0) $display("FAIL mid_irq: got %b want 0", irq); else n_pass++;
    for (int a = 0; a <= STAT; a++) begin
      rd(a, v);
      n_checks++; if (v !== 8'h00) $display("FAIL mid_read a=%0d: got %02h want 00", a, v); else n_pass++;
    end
    ce = 1'b1; repeat (3) step(); ce = 1'b0;
    rd(0, v);
    n_checks++; if (v !== 8'h00) $display("FAIL mid_stopped: got %02h want 00", v); else n_pass++;
  endtask

  task automatic test_random();
    int a, exp_d;
    bit exp_i;
    for (int n = 0; n < 600; n++) begin
      a = $urandom_range(0, 15);
      cs = ($urandom % 4) != 0;
      we = ($urandom % 2) != 0;
      addr = ADDR_W'(a);
      if (a % 4 == 1) din = 8'($urandom % 2);
      else if (a % 4 == 0 && a < STAT) din = 8'($urandom % 8);
      else din = 8'($urandom);
      ce = ($urandom % 4) != 0;
      ext_tick = ($urandom % 2) != 0;
      #1;
      exp_d = model_read(a);
      exp_i = model_irq();
      n_checks++;
      if (dout !== 8'(exp_d)) $display("FAIL rand_dout n=%0d a=%0d: got %02h want %02h", n, a, dout, exp_d);
      else n_pass++;
      n_checks++;
      if (irq !== exp_i) $display("FAIL rand_irq n=%0d: got %b want %b", n, irq, exp_i);
      else n_pass++;
      step();
    end
    cs = 1'b0; we = 1'b0; ce = 1'b0; ext_tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_commit_zero();
    test_collisions();
    test_read_latch();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
